// File: rtl/stream_tx_pkg.sv
// stream_tx_pkg: shared types and constants for the stream tx framer.
//   - tx_state_e : framer FSM states
//   - SYNC_DEFAULT, ID_W, LEN_W, BYTE_W : framing widths/constants
//   - HDR0_* : bit positions of id and len[9:8] inside the first header byte
//   - hdr0_byte(), csum_byte() : header packing and checksum finalisation
package stream_tx_pkg;

  localparam int ID_W   = 4;
  localparam int LEN_W  = 10;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

  // First header byte layout: {id, 2'b00, len[9:8]}
  localparam int HDR0_ID_MSB  = 7;
  localparam int HDR0_ID_LSB  = 4;
  localparam int HDR0_LEN_MSB = 1;
  localparam int HDR0_LEN_LSB = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HSEQ = 3'd1,
    HDR0 = 3'd2,
    HDR1 = 3'd3,
    PAY  = 3'd4,
    CSUM = 3'd5
  } tx_state_e;

  function automatic logic [BYTE_W-1:0] hdr0_byte(input logic [ID_W-1:0] id,
                                                  input logic [LEN_W-1:0] len);
    logic [BYTE_W-1:0] b;
    b = 8'h00;
    b[HDR0_ID_MSB:HDR0_ID_LSB]   = id;
    b[HDR0_LEN_MSB:HDR0_LEN_LSB] = len[LEN_W-1:BYTE_W];
    return b;
  endfunction

  // Two's complement of the running sum: makes all post-SYNC bytes sum to 0
  function automatic logic [BYTE_W-1:0] csum_byte(input logic [BYTE_W-1:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/tx_out_reg.sv
// tx_out_reg: one-entry holding register for the framed output byte.
//   clk, rst_n         : clock, async active-low reset
//   load, load_data    : request to present a new byte (taken only when slot_free)
//   tx_ready           : sink acceptance
//   tx_data, tx_valid  : registered output byte and its valid
//   slot_free          : register empty or being drained this cycle
module tx_out_reg
  import stream_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              slot_free
);

  assign slot_free = !tx_valid || tx_ready;

  // Output byte register: load when free, otherwise drain or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (slot_free && load) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (slot_free) begin
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= tx_valid;
    end
  end

endmodule

// File: rtl/stream_tx_framer.sv
// stream_tx_framer: serialises one selected-stream message at a time into
// SYNC | [SEQ] | HDR0 | HDR1 | payload | CSUM on a byte-wide valid/ready link.
//   clk, rst_n                      : clock, async active-low reset
//   strm_data/count/id/avail        : selected stream head byte and message info
//   strm_pull                       : consume one payload byte (combinational)
//   send_id                         : stream id being transmitted (held per frame)
//   tx_data, tx_valid, tx_ready     : framed output byte stream
// Optional: `define STREAM_TX_SEQ_EN inserts an 8-bit frame sequence byte
// after SYNC (covered by the checksum, advanced when CSUM loads).
module stream_tx_framer
  import stream_tx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE  = SYNC_DEFAULT,
  parameter int                GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] strm_data,
  input  logic [LEN_W-1:0]  strm_count,
  input  logic [ID_W-1:0]   strm_id,
  input  logic              strm_avail,
  output logic              strm_pull,
  output logic [ID_W-1:0]   send_id,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  tx_state_e         state_r, state_s;
  logic [ID_W-1:0]   send_id_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  rem_r;
  logic [BYTE_W-1:0] sum_r;
  logic [3:0]        gap_r;
  logic              slot_free_s;
  logic              load_s;
  logic [BYTE_W-1:0] load_data_s;
  logic              start_s;
  logic              add_s;
  logic              dec_s;
  logic              csum_s;
  logic              pull_s;
`ifdef STREAM_TX_SEQ_EN
  logic [BYTE_W-1:0] seq_r;
`endif

  tx_out_reg u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (load_data_s),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .slot_free (slot_free_s)
  );

  assign strm_pull = pull_s;
  assign send_id   = send_id_r;

  // Next-state and byte-select logic for the framing FSM
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    load_data_s = 8'h00;
    start_s     = 1'b0;
    add_s       = 1'b0;
    dec_s       = 1'b0;
    csum_s      = 1'b0;
    pull_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (strm_avail && slot_free_s && (gap_r == 4'd0)) begin
          start_s     = 1'b1;
          load_s      = 1'b1;
          load_data_s = SYNC_BYTE;
`ifdef STREAM_TX_SEQ_EN
          state_s     = HSEQ;
`else
          state_s     = HDR0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef STREAM_TX_SEQ_EN
      HSEQ: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = seq_r;
          add_s       = 1'b1;
          state_s     = HDR0;
        end else begin
          state_s = HSEQ;
        end
      end
`endif
      HDR0: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = hdr0_byte(send_id_r, len_r);
          add_s       = 1'b1;
          state_s     = HDR1;
        end else begin
          state_s = HDR0;
        end
      end
      HDR1: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = len_r[BYTE_W-1:0];
          add_s       = 1'b1;
          state_s     = (len_r != 10'd0) ? PAY : CSUM;
        end else begin
          state_s = HDR1;
        end
      end
      PAY: begin
        // Underflow (no avail) simply stalls; the frame is never aborted
        if (slot_free_s && strm_avail) begin
          load_s      = 1'b1;
          load_data_s = strm_data;
          pull_s      = 1'b1;
          add_s       = 1'b1;
          dec_s       = 1'b1;
          state_s     = (rem_r == 10'd1) ? CSUM : PAY;
        end else begin
          state_s = PAY;
        end
      end
      CSUM: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = csum_byte(sum_r);
          csum_s      = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = CSUM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Message info latched only at frame start; remaining count walks down in PAY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_id_r <= 4'd0;
      len_r     <= 10'd0;
      rem_r     <= 10'd0;
    end else if (start_s) begin
      send_id_r <= strm_id;
      len_r     <= strm_count;
      rem_r     <= strm_count;
    end else if (dec_s) begin
      rem_r <= rem_r - 10'd1;
    end
  end

  // Running checksum over every byte after SYNC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= 8'h00;
    end else if (csum_s) begin
      sum_r <= 8'h00;
    end else if (add_s) begin
      sum_r <= sum_r + load_data_s;
    end
  end

  // Inter-frame gap: counts only while the output register is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= 4'd0;
    end else if (csum_s) begin
      gap_r <= 4'(GAP_CYCLES);
    end else if ((gap_r != 4'd0) && !tx_valid) begin
      gap_r <= gap_r - 4'd1;
    end
  end

`ifdef STREAM_TX_SEQ_EN
  // Frame sequence number, advanced as each checksum byte is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_r <= 8'h00;
    end else if (csum_s) begin
      seq_r <= seq_r + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_tx_framer.sv
// tb_stream_tx_framer: directed scoreboard bench for stream_tx_framer.
module tb_stream_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] strm_data;
  logic [9:0] strm_count;
  logic [3:0] strm_id;
  logic       strm_avail;
  logic       strm_pull;
  logic [3:0] send_id;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  always #5 clk = ~clk;

  stream_tx_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .strm_data  (strm_data),
    .strm_count (strm_count),
    .strm_id    (strm_id),
    .strm_avail (strm_avail),
    .strm_pull  (strm_pull),
    .send_id    (send_id),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] id;
    logic       sync;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] pay_buf[$];
  int         msg_id_q[$];
  int         msg_cnt_q[$];
  int         msg_left_q[$];

  int   checks = 0;
  int   errors = 0;
  int   pulls = 0;
  int   exp_pulls = 0;
  int   accepts = 0;
  int   bubble_cnt = 0;
  bit   head_started = 0;
  bit   sync_seen = 0;
  bit   pull_smp = 0;
  bit   held_valid = 0;
  logic [7:0] held_data = 8'h00;
  bit   ready_toggle = 0;
  bit   avail_hold = 0;
  bit   bubble_watch = 0;
  logic [7:0] seq_model = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Queue a message in the source model and its expected frame in the scoreboard
  task automatic push_frame(input int id, input int cnt, input logic [7:0] hdr0,
                            input logic [7:0] csum_hand);
    exp_t e;
    logic [9:0] len;
    logic [7:0] cs;
    len = 10'(cnt);
    cs  = csum_hand;
    e.id = 4'(id);
    e.sync = 1'b1; e.data = 8'hA5; exp_q.push_back(e);
    e.sync = 1'b0;
`ifdef STREAM_TX_SEQ_EN
    e.data = seq_model; exp_q.push_back(e);
    cs = cs - seq_model;
    seq_model = seq_model + 8'd1;
`endif
    e.data = hdr0; exp_q.push_back(e);
    e.data = len[7:0]; exp_q.push_back(e);
    foreach (pay_buf[i]) begin
      e.data = pay_buf[i]; exp_q.push_back(e);
      src_q.push_back(pay_buf[i]);
    end
    e.data = cs; exp_q.push_back(e);
    msg_id_q.push_back(id);
    msg_cnt_q.push_back(cnt);
    msg_left_q.push_back(cnt);
    exp_pulls += cnt;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || msg_id_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    bubble_watch = 0;
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=%0d pending expected=0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #3;
  endtask

  task automatic wait_pulls(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pulls < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=%0d expected=%0d", name, pulls, target);
    end
    #3;
  endtask

  // Source model and input driver: inputs change on the falling edge only
  initial begin
    tx_ready   = 1'b1;
    strm_avail = 1'b0;
    strm_data  = 8'h00;
    strm_count = 10'd0;
    strm_id    = 4'd0;
    forever begin
      @(negedge clk);
      if (pull_smp) begin
        pulls++;
        if (msg_left_q.size() == 0 || src_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pull_extra actual=1 expected=0");
        end else begin
          void'(src_q.pop_front());
          msg_left_q[0] = msg_left_q[0] - 1;
        end
      end
      pull_smp = 0;
      if (sync_seen) begin
        head_started = 1;
        sync_seen = 0;
      end
      if (head_started && msg_left_q.size() != 0 && msg_left_q[0] == 0) begin
        void'(msg_id_q.pop_front());
        void'(msg_cnt_q.pop_front());
        void'(msg_left_q.pop_front());
        head_started = 0;
      end
      tx_ready = ready_toggle ? ~tx_ready : 1'b1;
      if (msg_id_q.size() != 0) begin
        strm_id    = 4'(msg_id_q[0]);
        strm_count = 10'(msg_cnt_q[0]);
        strm_avail = !avail_hold && !(head_started && msg_left_q[0] == 0);
      end else begin
        strm_avail = 1'b0;
      end
      strm_data = (src_q.size() != 0) ? src_q[0] : 8'h00;
      #1;
      if (rst_n) begin
        pull_smp = strm_pull;
        if (strm_pull) chk("pull_while_blocked", {31'd0, tx_valid && !tx_ready}, 32'd0);
        if (bubble_watch && !tx_valid) bubble_cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted byte
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held_valid = 0;
      end else begin
        if (held_valid) chk("stall_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held_data});
        if (tx_valid && tx_ready) begin
          accepts++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte actual=%0h expected=none", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e.data || send_id !== e.id) begin
              errors++;
              $display("FAIL byte actual=%0h/id%0h expected=%0h/id%0h", tx_data, send_id, e.data, e.id);
            end
            if (e.sync) sync_seen = 1;
          end
        end
        held_valid = tx_valid && !tx_ready;
        held_data  = tx_data;
      end
    end
  end

  initial begin
    int a0;
    int p0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_pull", {31'd0, strm_pull}, 32'd0);
    chk("rst_send_id", {28'd0, send_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #3;

    // Back-to-back frames, second one empty; no idle cycle between them
    pay_buf = '{8'h10, 8'h20, 8'h30};
    push_frame(1, 3, 8'h10, 8'h8D);
    pay_buf.delete();
    push_frame(0, 0, 8'h00, 8'h00);
    a0 = 0;
    while (accepts < 1 && a0 < 50) begin @(posedge clk); a0++; end
    bubble_watch = 1;
    wait_drain(200, "t1_drain");
    chk("t1_no_bubble", bubble_cnt, 0);
    chk("t1_pulls", pulls, exp_pulls);

    // Alternating tx_ready during the frame
    ready_toggle = 1;
    pay_buf = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_frame(2, 4, 8'h20, 8'hD2);
    wait_drain(300, "t2_drain");
    ready_toggle = 0;
    chk("t2_pulls", pulls, exp_pulls);

    // Stream underflow for 5 clocks mid-payload
    pay_buf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    push_frame(3, 6, 8'h30, 8'h65);
    wait_pulls(exp_pulls - 3, 200, "t3_wait");
    avail_hold = 1;
    @(negedge clk); #3;
    p0 = pulls;
    a0 = accepts;
    repeat (5) @(negedge clk);
    #3;
    chk("t3_no_pull_in_gap", pulls, p0);
    chk("t3_no_load_in_gap", accepts, a0);
    avail_hold = 0;
    wait_drain(200, "t3_drain");
    chk("t3_pulls", pulls, exp_pulls);

    // Maximum length message
    pay_buf.delete();
    for (int i = 0; i < 1023; i++) pay_buf.push_back(8'hFF);
    push_frame(1, 1023, 8'h13, 8'hED);
    wait_drain(3000, "t4_drain");
    chk("t4_pulls", pulls, exp_pulls);

    // Reset in the middle of a payload
    pay_buf = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_frame(5, 8, 8'h50, 8'h84);
    wait_pulls(exp_pulls - 6, 200, "t5_wait");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("t5_rst_pull", {31'd0, strm_pull}, 32'd0);
    chk("t5_rst_send_id", {28'd0, send_id}, 32'd0);
    exp_q.delete(); src_q.delete();
    msg_id_q.delete(); msg_cnt_q.delete(); msg_left_q.delete();
    head_started = 0; sync_seen = 0; pull_smp = 0; held_valid = 0;
    seq_model = 8'h00; pulls = 0; exp_pulls = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #3;
    pay_buf = '{8'hAA, 8'hBB};
    push_frame(6, 2, 8'h60, 8'h39);
    wait_drain(200, "t5_drain");
    chk("t5_pulls", pulls, exp_pulls);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
